sobel_frame_ctrl: RTL and testbench
===================================

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 64, pixels per line (legal range 3..4095).
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 64, lines per frame (legal range 3..4095).
REQ-003 SHALL have parameter COORD_W, default 12, width of coordinate counters.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 resetn  in  1  reset, synchronous, active-high: 1 = reset asserted.
REQ-006 in_valid  in  1  pixel-stream valid from source.
REQ-007 in_ready  out  1  controller accepts a pixel; acceptance = in_valid & in_ready.
REQ-008 lb_wr_en  out  1  line-buffer write strobe.
REQ-009 lb_addr  out  COORD_W  line-buffer column address.
REQ-010 win_shift  out  1  advance the 3x3 window one column.
REQ-011 out_valid  out  1  datapath output pixel is valid this cycle.
REQ-012 border  out  1  output pixel lies on the image border; datapath forces it to 0.
REQ-013 out_col / out_row  out  COORD_W each  coordinates of the current output pixel.
REQ-014 frame_done  out  1  one-cycle pulse after the last output of a frame.

Function
REQ-015 The block SHALL implement states IDLE, FILL, RUN, FLUSH and DONE.
REQ-016 IDLE->FILL on the first acceptance; FILL->RUN when accepted count reaches IMAGE_WIDTH+1; RUN->FLUSH on acceptance of pixel IMAGE_WIDTH*IMAGE_HEIGHT-1; FLUSH->DONE after IMAGE_WIDTH+1 flush cycles; DONE->IDLE unconditionally.
REQ-017 in_ready SHALL be 1 in IDLE, FILL and RUN, and 0 in FLUSH and DONE.
REQ-018 Input column and row counters SHALL advance only on acceptance, with column wrapping at IMAGE_WIDTH-1 and row incrementing on that wrap.
REQ-019 lb_wr_en, lb_addr (= input column) and win_shift SHALL be registered and assert in the cycle after an acceptance.
REQ-020 In FLUSH, win_shift SHALL be 1 on every cycle, lb_wr_en SHALL be 0, and lb_addr SHALL continue to count columns.
REQ-021 out_valid SHALL accompany win_shift whenever the frame index is at least IMAGE_WIDTH+1, so output index = input index - (IMAGE_WIDTH+1).
REQ-022 Exactly IMAGE_WIDTH*IMAGE_HEIGHT out_valid pulses SHALL occur per frame, in raster order from (0,0).
REQ-023 border SHALL = out_valid & (out_row==0 | out_row==IMAGE_HEIGHT-1 | out_col==0 | out_col==IMAGE_WIDTH-1).
REQ-024 A cycle with in_valid=0 in IDLE, FILL or RUN SHALL hold all counters and deassert all strobes (bubbles allowed).
REQ-025 in_valid=1 during FLUSH or DONE SHALL be ignored: nothing is counted and no strobes are generated.
REQ-026 frame_done SHALL be high only in DONE; a new frame MAY be accepted starting in the following IDLE cycle.

Reset
REQ-027 On a clock edge with resetn=1, the block SHALL enter IDLE, zero all counters and drive every output to 0 except in_ready, which SHALL be 1 from the first cycle after reset releases.
REQ-028 A reset asserted mid-frame SHALL abandon the frame with no flush and no frame_done.

Configuration
REQ-029 With SOBEL_CTRL_STATS_EN defined, the block SHALL add output frame_cnt (16 bits, reset 0), which increments in DONE and wraps 0xFFFF->0.
REQ-030 With SOBEL_CTRL_STATS_EN defined, the block SHALL add output drop_cnt (16 bits, reset 0), which counts cycles with in_valid=1 and in_ready=0 and saturates at 0xFFFF.
REQ-031 Without SOBEL_CTRL_STATS_EN, both ports and their logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package sobel_pkg SHALL hold the IMAGE_WIDTH and IMAGE_HEIGHT defaults, COORD_W, and the state enumeration.
REQ-033 Sub-module px_coord_counter (column/row raster counter with wrap and last-pixel flag) SHALL be instantiated twice: once for input coordinates and once for output coordinates.

Verification
REQ-034 Scenario: W=H=64, continuous in_valid -> 4096 out_valid pulses; frame_done exactly 65 cycles after the last acceptance plus pipeline; first out_valid on the cycle after acceptance 65.
REQ-035 Scenario: W=H=4, in_valid toggled 1/0 -> 16 outputs in raster order; border=1 on 12 of them; interior (1,1),(1,2),(2,1),(2,2) have border=0.
REQ-036 Scenario: in_valid held 1 through FLUSH -> in_ready=0 for 6 cycles (W=4: 5 FLUSH + 1 DONE); no lb_wr_en; drop_cnt=6 with the macro defined.
REQ-037 Scenario: resetn=1 at pixel 30 of a W=H=8 frame -> next cycle IDLE, all outputs 0, in_ready=1; a fresh frame then produces 64 outputs.
REQ-038 Scenario: three back-to-back W=H=4 frames -> 48 outputs, three frame_done pulses, frame_cnt=3.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults and the controller state enumeration for the
// Sobel frame controller.
//   DEF_IMAGE_WIDTH  - default pixels per line
//   DEF_IMAGE_HEIGHT - default lines per frame
//   DEF_COORD_W      - default width of the column/row coordinate counters
//   state_t          - controller states (also driven on the state_dbg port)
package sobel_pkg;

  localparam int DEF_IMAGE_WIDTH  = 64;
  localparam int DEF_IMAGE_HEIGHT = 64;
  localparam int DEF_COORD_W      = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/px_coord_counter.sv
// px_coord_counter: raster column/row counter.
//   clk   - clock, rising edge
//   reset - synchronous, active-high; zeroes both coordinates
//   clear - synchronous clear back to (0,0)
//   adv   - advance one pixel in raster order; wraps (W-1,H-1) -> (0,0)
//   col   - current column
//   row   - current row
//   last  - current position is the final pixel of the frame
module px_coord_counter
  import sobel_pkg::*;
#(
  parameter int W  = DEF_IMAGE_WIDTH,
  parameter int H  = DEF_IMAGE_HEIGHT,
  parameter int CW = DEF_COORD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          last
);

  logic col_end;
  logic row_end;

  assign col_end = (col == CW'(W - 1));
  assign row_end = (row == CW'(H - 1));
  assign last    = col_end & row_end;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: frame sequencing for a 3x3 Sobel datapath fed by a
// pixel stream. Tracks input and output raster positions, drives line-buffer
// writes and window shifts, and flushes the window after the last pixel.
//   clk        - clock, rising edge
//   resetn     - synchronous reset, active-high (1 = reset)
//   in_valid   - source pixel valid
//   in_ready   - pixel accepted when in_valid & in_ready
//   lb_wr_en   - line-buffer write strobe (cycle after acceptance)
//   lb_addr    - line-buffer column address
//   win_shift  - advance the 3x3 window one column
//   out_valid  - datapath output pixel valid
//   border     - output pixel is on the image border
//   out_col    - output pixel column
//   out_row    - output pixel row
//   frame_done - one-cycle pulse alongside the last output of a frame
//   frame_cnt  - completed frames, wraps (only with SOBEL_CTRL_STATS_EN)
//   drop_cnt   - cycles with in_valid while not ready, saturates
//                (only with SOBEL_CTRL_STATS_EN)
//   state_dbg  - current controller state
// Handshake: a pixel transfers on a rising edge where in_valid & in_ready;
// in_ready depends only on state, never on in_valid.
// Optional statistics are built when macro SOBEL_CTRL_STATS_EN is defined.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int COORD_W      = DEF_COORD_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               lb_wr_en,
  output logic [COORD_W-1:0] lb_addr,
  output logic               win_shift,
  output logic               out_valid,
  output logic               border,
  output logic [COORD_W-1:0] out_col,
  output logic [COORD_W-1:0] out_row,
  output logic               frame_done,
`ifdef SOBEL_CTRL_STATS_EN
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt,
`endif
  output logic [2:0]         state_dbg
);

  state_t state;
  state_t state_nx;

  logic               acc;
  logic               flushing;
  logic [COORD_W-1:0] in_col;
  logic [COORD_W-1:0] in_row;
  logic               in_last;
  logic               at_w;
  logic               out_last;

  assign in_ready  = (state == S_IDLE) || (state == S_FILL) || (state == S_RUN);
  assign acc       = in_valid & in_ready;
  assign flushing  = (state == S_FLUSH);
  assign state_dbg = state;

  // The input counter keeps stepping through FLUSH so lb_addr keeps counting
  // columns; it is cleared in DONE so the next frame starts at (0,0).
  px_coord_counter #(
    .W (IMAGE_WIDTH),
    .H (IMAGE_HEIGHT),
    .CW(COORD_W)
  ) u_in_coord (
    .clk  (clk),
    .reset(resetn),
    .clear(state == S_DONE),
    .adv  (acc | flushing),
    .col  (in_col),
    .row  (in_row),
    .last (in_last)
  );

  // Position (0,1) is raster index IMAGE_WIDTH. Accepting it completes the
  // fill of IMAGE_WIDTH+1 pixels; reaching it again in FLUSH (counter
  // restarted from (0,0) after the last pixel) marks the final flush cycle.
  assign at_w = (in_row == COORD_W'(1)) && (in_col == '0);

  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (acc) state_nx = S_FILL;
      S_FILL:  if (acc && at_w) state_nx = S_RUN;
      S_RUN:   if (acc && in_last) state_nx = S_FLUSH;
      S_FLUSH: if (at_w) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Strobes lag the event that causes them by one cycle. Pixels accepted in
  // FILL only prime the window; every RUN acceptance and every FLUSH cycle
  // yields one output pixel.
  always_ff @(posedge clk) begin
    if (resetn) begin
      lb_wr_en  <= 1'b0;
      win_shift <= 1'b0;
      out_valid <= 1'b0;
      lb_addr   <= '0;
    end else begin
      lb_wr_en  <= acc;
      win_shift <= acc | flushing;
      out_valid <= (acc && (state == S_RUN)) || flushing;
      if (acc || flushing) begin
        lb_addr <= in_col;
      end
    end
  end

  px_coord_counter #(
    .W (IMAGE_WIDTH),
    .H (IMAGE_HEIGHT),
    .CW(COORD_W)
  ) u_out_coord (
    .clk  (clk),
    .reset(resetn),
    .clear(1'b0),
    .adv  (out_valid),
    .col  (out_col),
    .row  (out_row),
    .last (out_last)
  );

  assign border = out_valid &
                  ((out_row == '0) || (out_row == COORD_W'(IMAGE_HEIGHT - 1)) ||
                   (out_col == '0) || (out_col == COORD_W'(IMAGE_WIDTH - 1)));

  // DONE coincides with the final flush output, so the output counter sits
  // on the last pixel whenever the state is DONE.
  assign frame_done = (state == S_DONE) & out_last;

`ifdef SOBEL_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (state == S_DONE) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (in_valid && !in_ready && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: randomized scoreboard bench for sobel_frame_ctrl.
// A non-square 6x5 image is used so width/height mix-ups show up.
module tb_sobel_frame_ctrl;
  import sobel_pkg::*;

  localparam int W    = 6;
  localparam int H    = 5;
  localparam int CW   = 12;
  localparam int NPIX = W * H;

  // clock / reset / DUT
  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          lb_wr_en;
  logic [CW-1:0] lb_addr;
  logic          win_shift;
  logic          out_valid;
  logic          border;
  logic [CW-1:0] out_col;
  logic [CW-1:0] out_row;
  logic          frame_done;
  logic [2:0]    state_dbg;
`ifdef SOBEL_CTRL_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   drop_cnt;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_frame_ctrl #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .COORD_W     (CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lb_wr_en  (lb_wr_en),
    .lb_addr   (lb_addr),
    .win_shift (win_shift),
    .out_valid (out_valid),
    .border    (border),
    .out_col   (out_col),
    .out_row   (out_row),
    .frame_done(frame_done),
`ifdef SOBEL_CTRL_STATS_EN
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt),
`endif
    .state_dbg (state_dbg)
  );

  // scoreboard
  typedef struct packed {
    logic [31:0]   cyc;
    logic          flush;
    logic          brd;
    logic [CW-1:0] lbaddr;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } out_exp_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [CW-1:0] addr;
  } lb_exp_t;

  out_exp_t    exp_q[$];
  lb_exp_t     lb_q[$];
  logic [31:0] done_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // reference model state
  int k      = 0;  // raster index of next pixel to be accepted
  int block  = 0;  // remaining not-ready cycles after a frame's last pixel
  int frames = 0;  // frames completed since reset
  int drops  = 0;  // in_valid cycles while not ready since reset

  function automatic out_exp_t mk_out(int idx, int at, bit fl, int lba);
    out_exp_t e;
    int c;
    int r;
    c        = idx % W;
    r        = idx / W;
    e.cyc    = at;
    e.flush  = fl;
    e.col    = CW'(c);
    e.row    = CW'(r);
    e.lbaddr = CW'(lba);
    e.brd    = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    return e;
  endfunction

  // driver: one cycle of stimulus, with the model predicting acceptance
  task automatic step(bit v);
    bit exp_ready;
    lb_exp_t le;
    @(negedge clk);
    exp_ready = (block == 0);
    check("in_ready", in_ready, exp_ready);
    in_valid = v;
    if (v && exp_ready) begin
      le.cyc  = cyc + 1;
      le.addr = CW'(k % W);
      lb_q.push_back(le);
      // The window needs W+1 pixels before it can emit output 0.
      if (k >= W + 1) exp_q.push_back(mk_out(k - (W + 1), cyc + 1, 1'b0, 0));
      k++;
      if (k == NPIX) begin
        for (int j = 0; j <= W; j++)
          exp_q.push_back(mk_out(NPIX - (W + 1) + j, cyc + 2 + j, 1'b1, j % W));
        done_q.push_back(cyc + W + 2);
        k = 0;
        block = W + 2;
        frames++;
      end
    end else begin
      if (v && !exp_ready) drops++;
      if (block > 0) block--;
    end
  endtask

  task automatic run_frame(int mode);
    int f0;
    int n;
    bit v;
    f0 = frames;
    n  = 0;
    while ((frames == f0 || block > 0) && n < 20 * NPIX) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2) == 0;
        default: v = $urandom_range(0, 99) < 70;
      endcase
      step(v);
      n++;
    end
    check("frame_completed_in_budget", (n < 20 * NPIX), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn   = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    lb_q.delete();
    done_q.delete();
    k = 0;
    block = 0;
    frames = 0;
    drops = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_lb_wr_en", lb_wr_en, 1'b0);
    check("rst_lb_addr", lb_addr, 0);
    check("rst_win_shift", win_shift, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_border", border, 1'b0);
    check("rst_out_col", out_col, 0);
    check("rst_out_row", out_row, 0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_state", state_dbg, S_IDLE);
`ifdef SOBEL_CTRL_STATS_EN
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    resetn = 1'b0;
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a strobe
  always @(negedge clk) begin
    out_exp_t oe;
    lb_exp_t le;
    if (lb_wr_en) begin
      if (lb_q.size() == 0) check("lb_wr_en_unexpected", lb_wr_en, 1'b0);
      else begin
        le = lb_q.pop_front();
        check("lb_cycle", cyc, le.cyc);
        check("lb_addr", lb_addr, le.addr);
        check("lb_win_shift", win_shift, 1'b1);
      end
    end
    if (out_valid) begin
      if (exp_q.size() == 0) check("out_valid_unexpected", out_valid, 1'b0);
      else begin
        oe = exp_q.pop_front();
        check("out_cycle", cyc, oe.cyc);
        check("out_col", out_col, oe.col);
        check("out_row", out_row, oe.row);
        check("border", border, oe.brd);
        if (oe.flush) begin
          check("flush_lb_addr", lb_addr, oe.lbaddr);
          check("flush_win_shift", win_shift, 1'b1);
          check("flush_lb_wr_en", lb_wr_en, 1'b0);
        end
      end
    end else if (border) begin
      check("border_without_valid", border, 1'b0);
    end
    if (win_shift && !lb_wr_en && !out_valid) check("win_shift_stray", win_shift, 1'b0);
    if (frame_done) begin
      if (done_q.size() == 0) check("frame_done_unexpected", frame_done, 1'b0);
      else check("frame_done_cycle", cyc, done_q.pop_front());
    end
  end

  // stimulus sequence and final report
  initial begin
    do_reset();
    run_frame(0);                // continuous valid, held through flush
    run_frame(1);                // valid toggling 1/0
    run_frame(0);                // three back-to-back frames
    run_frame(0);
    run_frame(0);
    step(1'b0);
`ifdef SOBEL_CTRL_STATS_EN
    check("frame_cnt_mid", frame_cnt, frames);
    check("drop_cnt_mid", drop_cnt, drops);
`endif
    run_frame(2);
    run_frame(2);
    repeat (17) step(1'b1);      // abandon a frame part way through
    do_reset();
    run_frame(2);
    run_frame(0);
    repeat (W + 6) step(1'b0);
    check("out_queue_drained", exp_q.size(), 0);
    check("lb_queue_drained", lb_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
`ifdef SOBEL_CTRL_STATS_EN
    check("frame_cnt_end", frame_cnt, frames);
    check("drop_cnt_end", drop_cnt, drops);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
